// File: rtl/adda_pkg.sv
// Shared definitions for the J2 ADC/DAC path: sample width, default ADC
// pipeline latency and the sampler state type.
package adda_pkg;
  localparam int ADC_DATA_W   = 8;
  localparam int ADC_PIPE_LAT = 3;

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_e;
endpackage

// File: rtl/adc_clk_div.sv
// Programmable half-period divider producing the ADC conversion clock and a
// strobe that is high on the i_clk edge where that clock falls.
module adc_clk_div #(
  parameter int DIV_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_run,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_ad_clk,
  output logic             o_fall
);
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] lim_m1;
  logic             wrap;

  // >= rather than == so shrinking i_div mid-count wraps immediately.
  assign lim_m1 = (i_div == '0) ? '0 : i_div - DIV_W'(1);
  assign wrap   = cnt >= lim_m1;
  assign o_fall = i_run & wrap & o_ad_clk;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt      <= '0;
      o_ad_clk <= 1'b0;
    end else if (!i_run) begin
      cnt      <= '0;
      o_ad_clk <= 1'b0;
    end else if (wrap) begin
      cnt      <= '0;
      o_ad_clk <= ~o_ad_clk;
    end else begin
      cnt      <= cnt + DIV_W'(1);
    end
  end
endmodule

// File: rtl/adc_sampler.sv
// ADC front end: conversion clock, start-up discard of pipeline samples,
// one-deep valid/ready output register, sticky overrun and clearable peak.
module adc_sampler
  import adda_pkg::*;
#(
  parameter int DIV_W    = 16,
  parameter int PIPE_LAT = ADC_PIPE_LAT,
  parameter int DATA_W   = ADC_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic [DIV_W-1:0]  i_div,
  output logic              o_ad_clk,
  input  logic [DATA_W-1:0] i_ad_data,
  output logic [DATA_W-1:0] o_sample,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_overrun,
  input  logic              i_ovr_clr,
  output logic [DATA_W-1:0] o_peak,
  input  logic              i_peak_clr
);
  localparam int DISC_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT + 1) : 1;

  state_e            state;
  logic [DISC_W-1:0] disc;
  logic              run, fall, cap, xfer, ovr_set;

  assign run     = i_enable & (state != IDLE);
  assign cap     = fall & (state == RUN);
  assign xfer    = o_valid & i_ready;
  assign ovr_set = cap & o_valid & ~i_ready;

  adc_clk_div #(.DIV_W(DIV_W)) u_div (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_run    (run),
    .i_div    (i_div),
    .o_ad_clk (o_ad_clk),
    .o_fall   (fall)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      disc  <= '0;
    end else if (!i_enable) begin
      state <= IDLE;
      disc  <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= (PIPE_LAT == 0) ? RUN : PRIME;
          disc  <= '0;
        end
        PRIME: if (fall) begin
          // The PIPE_LAT-th discarded capture hands over to RUN.
          if (disc == DISC_W'(PIPE_LAT - 1)) begin
            state <= RUN;
            disc  <= '0;
          end else begin
            disc  <= disc + DISC_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_sample  <= '0;
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
      o_peak    <= '0;
    end else begin
      if (cap) begin
        o_sample <= i_ad_data;
        o_valid  <= 1'b1;
      end else if (xfer) begin
        o_valid  <= 1'b0;
      end

      if (ovr_set)        o_overrun <= 1'b1;
      else if (i_ovr_clr) o_overrun <= 1'b0;

      // A clear coinciding with a capture restarts the peak at that sample.
      if (cap && (i_peak_clr || i_ad_data > o_peak)) o_peak <= i_ad_data;
      else if (i_peak_clr)                            o_peak <= '0;
    end
  end
endmodule
